iic_slavemod: RTL and testbench

I2C target (slave) that emulates a 24Cxx-style byte-addressed EEPROM with an on-chip register memory. It is the responder end of the I2C write/read master already in the design and lets that master be exercised on-chip without an external EEPROM. It decodes START/STOP, matches the device address, ACKs bytes, accepts writes, and serves random, current-address and sequential reads. A local read port exposes memory contents to fabric logic.

---
 rtl/iic_slavemod_pkg.sv | 22 ++
 rtl/iic_busdet.sv | 40 ++++
 rtl/iic_slavemod.sv | 212 +++++++++++++++++++++
 tb/tb_iic_slavemod.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_slavemod_pkg.sv
// rtl/iic_slavemod_pkg.sv - shared types and constants for the I2C EEPROM-emulating target
package iic_slavemod_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        ACK_DEV,
        WORDADDR,
        ACK_WORD,
        WDATA,
        ACK_WDATA,
        RDATA,
        MACK,
        WAIT_STOP
    } iicState_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;

endpackage

// File: rtl/iic_busdet.sv
// rtl/iic_busdet.sv - SCL/SDA synchronizers with edge and START/STOP strobes
module iic_busdet (
    input  logic CLOCK,
    input  logic RESET,
    input  logic SCL,
    input  logic SDA,
    output logic sdaIn,
    output logic sclRise,
    output logic sclFall,
    output logic startDet,
    output logic stopDet
);

    logic [1:0] sclSync;
    logic [1:0] sdaSync;
    logic       sclHist;
    logic       sdaHist;

    // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
            sclHist <= 1'b1;
            sdaHist <= 1'b1;
        end else begin
            sclSync <= {sclSync[0], SCL};
            sdaSync <= {sdaSync[0], SDA};
            sclHist <= sclSync[1];
            sdaHist <= sdaSync[1];
        end
    end

    assign sdaIn    = sdaSync[1];
    assign sclRise  =  sclSync[1] & ~sclHist;
    assign sclFall  = ~sclSync[1] &  sclHist;
    assign startDet =  sclSync[1] &  sclHist &  sdaHist & ~sdaSync[1];
    assign stopDet  =  sclSync[1] &  sclHist & ~sdaHist &  sdaSync[1];

endmodule

// File: rtl/iic_slavemod.sv
// rtl/iic_slavemod.sv - 24Cxx-style I2C EEPROM target with local read port; IIC_SLAVE_WP_EN adds iWP
module iic_slavemod
    import iic_slavemod_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         AW       = 8
) (
    input  logic          CLOCK,
    input  logic          RESET,
`ifdef IIC_SLAVE_WP_EN
    input  logic          iWP,
`endif
    input  logic          SCL,
    inout  wire           SDA,
    input  logic [AW-1:0] iRdAddr,
    output logic [7:0]    oRdData,
    output logic          oDone,
    output logic          oBusy
);

    logic sdaIn, sclRise, sclFall, startDet, stopDet;
    logic wpActive;

    iic_busdet uBusdet (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .SCL      (SCL),
        .SDA      (SDA),
        .sdaIn    (sdaIn),
        .sclRise  (sclRise),
        .sclFall  (sclFall),
        .startDet (startDet),
        .stopDet  (stopDet)
    );

`ifdef IIC_SLAVE_WP_EN
    assign wpActive = iWP;
`else
    assign wpActive = 1'b0;
`endif

    iicState_t     state, stateNext;
    logic [3:0]    bitCnt, bitCntNext;
    logic [7:0]    shiftReg, shiftNext;
    logic          rwBit, rwNext;
    logic [AW-1:0] ptr, ptrNext;
    logic          written, writtenNext;
    logic          sdaOe, sdaOeNext;
    logic          busyNext, doneNext;
    logic          memWe;
    logic [7:0]    mem [2**AW];
    logic [7:0]    memAtPtr;
    logic [7:0]    rxByte;

    assign memAtPtr = mem[ptr];
    assign rxByte   = {shiftReg[6:0], sdaIn};
    assign SDA      = sdaOe ? I2C_ACK : 1'bz;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
            rwBit    <= 1'b0;
            ptr      <= '0;
            written  <= 1'b0;
            sdaOe    <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            rwBit    <= rwNext;
            ptr      <= ptrNext;
            written  <= writtenNext;
            sdaOe    <= sdaOeNext;
            oBusy    <= busyNext;
            oDone    <= doneNext;
        end
    end

    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        shiftNext   = shiftReg;
        rwNext      = rwBit;
        ptrNext     = ptr;
        writtenNext = written;
        sdaOeNext   = sdaOe;
        busyNext    = oBusy;
        doneNext    = 1'b0;
        memWe       = 1'b0;
        if (startDet) begin
            stateNext  = DEVADDR;
            bitCntNext = '0;
            busyNext   = 1'b1;
            sdaOeNext  = 1'b0;
        end else if (stopDet) begin
            stateNext   = IDLE;
            bitCntNext  = '0;
            busyNext    = 1'b0;
            sdaOeNext   = 1'b0;
            doneNext    = written;
            writtenNext = 1'b0;
        end else begin
            case (state)
                DEVADDR, WORDADDR, WDATA: begin
                    if (sclRise) begin
                        shiftNext  = rxByte;
                        bitCntNext = bitCnt + 4'd1;
                        // Data bytes commit on the 8th rise; a STOP before that leaves memory untouched.
                        if (state == WDATA && bitCnt == 4'd7) begin
                            ptrNext = ptr + AW'(1);
                            if (!wpActive) begin
                                memWe       = 1'b1;
                                writtenNext = 1'b1;
                            end
                        end
                    end else if (sclFall && bitCnt == 4'd8) begin
                        bitCntNext = '0;
                        case (state)
                            DEVADDR: begin
                                if (shiftReg[7:1] == DEV_ADDR) begin
                                    stateNext = ACK_DEV;
                                    sdaOeNext = 1'b1;
                                    rwNext    = shiftReg[0];
                                end else begin
                                    stateNext = WAIT_STOP;
                                    sdaOeNext = 1'b0;
                                end
                            end
                            WORDADDR: begin
                                ptrNext   = shiftReg[AW-1:0];
                                stateNext = ACK_WORD;
                                sdaOeNext = 1'b1;
                            end
                            default: begin
                                stateNext = ACK_WDATA;
                                sdaOeNext = !wpActive;
                            end
                        endcase
                    end
                end
                ACK_DEV: begin
                    if (sclFall) begin
                        if (rwBit) begin
                            // The MSB goes out on the same fall that ends the address ACK.
                            stateNext  = RDATA;
                            shiftNext  = {memAtPtr[6:0], 1'b0};
                            sdaOeNext  = ~memAtPtr[7];
                            ptrNext    = ptr + AW'(1);
                            bitCntNext = 4'd1;
                        end else begin
                            stateNext  = WORDADDR;
                            sdaOeNext  = 1'b0;
                            bitCntNext = '0;
                        end
                    end
                end
                ACK_WORD, ACK_WDATA: begin
                    if (sclFall) begin
                        stateNext  = WDATA;
                        sdaOeNext  = 1'b0;
                        bitCntNext = '0;
                    end
                end
                RDATA: begin
                    if (sclFall) begin
                        if (bitCnt == 4'd8) begin
                            stateNext  = MACK;
                            sdaOeNext  = 1'b0;
                            bitCntNext = '0;
                        end else begin
                            sdaOeNext  = ~shiftReg[7];
                            shiftNext  = {shiftReg[6:0], 1'b0};
                            bitCntNext = bitCnt + 4'd1;
                        end
                    end
                end
                MACK: begin
                    if (sclRise) begin
                        if (sdaIn == I2C_ACK) begin
                            stateNext  = RDATA;
                            shiftNext  = memAtPtr;
                            ptrNext    = ptr + AW'(1);
                            bitCntNext = '0;
                        end else begin
                            stateNext = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (memWe) begin
            mem[ptr] <= rxByte;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            oRdData <= '0;
        end else begin
            oRdData <= mem[iRdAddr];
        end
    end

endmodule

// File: tb/tb_iic_slavemod.sv
// tb/tb_iic_slavemod.sv - directed I2C master with a byte-level EEPROM model
module tb_iic_slavemod;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       SCL   = 1'b1;
    logic       mSda  = 1'b1;
    logic       iWP   = 1'b0;
    logic [7:0] iRdAddr = 8'h00;
    logic [7:0] oRdData;
    logic       oDone;
    logic       oBusy;
    wire        SDA;

    pullup (SDA);
    assign SDA = mSda ? 1'bz : 1'b0;

    iic_slavemod dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
`ifdef IIC_SLAVE_WP_EN
        .iWP     (iWP),
`endif
        .SCL     (SCL),
        .SDA     (SDA),
        .iRdAddr (iRdAddr),
        .oRdData (oRdData),
        .oDone   (oDone),
        .oBusy   (oBusy)
    );

    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    // Byte-level EEPROM model
    logic [7:0] modelMem [256];
    bit         known    [256];
    logic [7:0] mPtr     = 8'h00;
    int         mPhase   = 0;
    bit         mWritten = 1'b0;
    int         expDone  = 0;
    int         doneCnt  = 0;
    bit         expBusy  = 1'b0;
    bit         chkEn    = 1'b0;
    bit         holdAddr = 1'b0;
    logic [7:0] addrList [8] = '{8'h10, 8'h11, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h20, 8'h40};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLOCK);
            #2;
            if (!holdAddr) iRdAddr = addrList[$urandom_range(0, 7)];
        end
    end

    initial begin
        logic [7:0] a;
        forever begin
            @(posedge CLOCK);
            a = iRdAddr;
            @(negedge CLOCK);
            if (oDone) doneCnt++;
            if (chkEn) begin
                chk("busy_track", oBusy, expBusy);
                if (!expBusy && known[a]) chk("rd_port", oRdData, modelMem[a]);
            end
        end
    end

    task automatic q();
        repeat (6) @(posedge CLOCK);
        #1;
    endtask

    task automatic sendBit(input logic b);
        mSda = b; q(); SCL = 1'b1; q(); q(); SCL = 1'b0; q();
    endtask

    task automatic readBit(output logic b);
        mSda = 1'b1; q(); SCL = 1'b1; q(); b = SDA; q(); SCL = 1'b0; q();
    endtask

    task automatic mStart();
        chkEn = 1'b0;
        mSda = 1'b1; q(); SCL = 1'b1; q(); mSda = 1'b0; q(); SCL = 1'b0; q();
        mPhase  = 0;
        expBusy = 1'b1;
        chkEn   = 1'b1;
    endtask

    task automatic mStop();
        chkEn = 1'b0;
        mSda = 1'b0; q(); SCL = 1'b1; q(); mSda = 1'b1; q(); q();
        expBusy = 1'b0;
        chkEn   = 1'b1;
        if (mWritten) expDone++;
        mWritten = 1'b0;
        chk("done_count", doneCnt, expDone);
        chk("sda_released", SDA, 1'b1);
    endtask

    task automatic mWrite(input logic [7:0] b, output logic ackBit);
        logic expAck;
        case (mPhase)
            0: begin
                expAck = (b[7:1] == 7'h50);
                mPhase = !expAck ? 3 : (b[0] ? 4 : 1);
            end
            1: begin
                expAck = 1'b1;
                mPtr   = b;
                mPhase = 2;
            end
            2: begin
                expAck = !iWP;
                if (!iWP) begin
                    modelMem[mPtr] = b;
                    known[mPtr]    = 1'b1;
                    mWritten       = 1'b1;
                end
                mPtr = mPtr + 8'd1;
            end
            default: expAck = 1'b0;
        endcase
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        readBit(ackBit);
        chk($sformatf("ack_%02h", b), ackBit, expAck ? 1'b0 : 1'b1);
    endtask

    task automatic mRead(input bit last, output logic [7:0] got);
        logic [7:0] exp;
        logic       bv;
        exp  = modelMem[mPtr];
        if (known[mPtr]) begin end
        mPtr = mPtr + 8'd1;
        for (int i = 7; i >= 0; i--) begin
            readBit(bv);
            got[i] = bv;
        end
        chk("read_byte", got, exp);
        sendBit(last);
    endtask

    task automatic wrTxn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic ack;
        mStart(); mWrite(b0, ack); mWrite(b1, ack); mWrite(b2, ack); mStop();
    endtask

    task automatic peek(input logic [7:0] addr, input logic [7:0] exp);
        holdAddr = 1'b1;
        iRdAddr  = addr;
        repeat (2) @(posedge CLOCK);
        #1;
        chk($sformatf("peek_%02h", addr), oRdData, exp);
        holdAddr = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_done", oDone, 1'b0);
        chk("rst_rddata", oRdData, 8'h00);
        chk("rst_sda", SDA, 1'b1);
        RESET = 1'b0;
        q();
        chkEn = 1'b1;

        // Single write
        wrTxn(8'hA0, 8'h10, 8'h5A);
        chk("done_once", doneCnt, 1);
        peek(8'h10, 8'h5A);

        // Preload known bytes used by later reads
        wrTxn(8'hA0, 8'h01, 8'h9C);
        wrTxn(8'hA0, 8'h11, 8'hC3);
        wrTxn(8'hA0, 8'h20, 8'h5F);
        wrTxn(8'hA0, 8'h40, 8'h00);

        // Sequential write wrapping through 0xFF
        mStart(); mWrite(8'hA0, ack); mWrite(8'hFE, ack);
        mWrite(8'h11, ack); mWrite(8'h22, ack); mWrite(8'h33, ack); mStop();
        peek(8'hFE, 8'h11);
        peek(8'hFF, 8'h22);
        peek(8'h00, 8'h33);

        // Current-address read lands on 0x01
        mStart(); mWrite(8'hA1, ack); mRead(1'b1, d); mStop();
        chk("cur_read", d, 8'h9C);

        // Random read with repeated START, ACK then NACK
        mStart(); mWrite(8'hA0, ack); mWrite(8'h10, ack);
        mStart(); mWrite(8'hA1, ack);
        mRead(1'b0, d); chk("rand_read0", d, 8'h5A);
        mRead(1'b1, d); chk("rand_read1", d, 8'hC3);
        mStop();

        // Address mismatch: NACK and ignored bytes
        mStart(); mWrite(8'hA2, ack); mWrite(8'h10, ack); mWrite(8'hEE, ack); mStop();
        peek(8'h10, 8'h5A);

        // STOP after 4 data bits
        mStart(); mWrite(8'hA0, ack); mWrite(8'h20, ack);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0);
        mStop();
        peek(8'h20, 8'h5F);

        // Reset while driving a 0 data bit
        mStart(); mWrite(8'hA0, ack); mWrite(8'h40, ack);
        mStart(); mWrite(8'hA1, ack);
        mSda = 1'b1; q(); SCL = 1'b1; q();
        chk("rdata_drive", SDA, 1'b0);
        chkEn = 1'b0;
        RESET = 1'b1;
        #1;
        chk("rst_mid_sda", SDA, 1'b1);
        chk("rst_mid_busy", oBusy, 1'b0);
        chk("rst_mid_rddata", oRdData, 8'h00);
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        mPtr = 8'h00; mPhase = 0; mWritten = 1'b0; expBusy = 1'b0;
        q(); q();
        chkEn = 1'b1;
        mStart(); mWrite(8'hA1, ack); mRead(1'b1, d); mStop();
        chk("ptr_after_reset", d, 8'h33);

`ifdef IIC_SLAVE_WP_EN
        iWP = 1'b1;
        wrTxn(8'hA0, 8'h20, 8'h77);
        iWP = 1'b0;
        peek(8'h20, 8'h5F);
`endif

        q();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
